// File: rtl/multiplier_pkg.sv
// Shared constants for the unsigned array multiplier: widths and result latencies.
// Optional pipeline stage selected by the MULTIPLIER_PIPE_EN macro.
package multiplier_pkg;

   localparam int DEFAULT_W    = 2;
   localparam int MAX_W        = 8;
   localparam int LATENCY_BASE = 1;
   localparam int LATENCY_PIPE = 2;

`ifdef MULTIPLIER_PIPE_EN
   localparam int LATENCY = LATENCY_PIPE;
`else
   localparam int LATENCY = LATENCY_BASE;
`endif

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the rows of the array multiplier.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/multiplier_2x2.sv
// Unsigned WxW array multiplier: combinational product P plus a registered product P_q.
// Defining MULTIPLIER_PIPE_EN adds a register stage after the first adder row (latency 2).
module multiplier_2x2
   import multiplier_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic           in_valid,
   output logic [2*W-1:0] P,
   output logic [2*W-1:0] P_q,
   output logic           out_valid
);

   // up0[i] is the W-bit running sum entering row i, aligned to weight 2^i;
   // lo0[i] is the settled product bit i.
   logic [W-1:0] up0 [1:W];
   logic [W-1:0] lo0;

   assign lo0[0] = A[0] & B[0];
   assign up0[1] = {1'b0, A[W-1:1] & {(W-1){B[0]}}};

   for (genvar i = 1; i < W; i++) begin : g_row
      logic [W-1:0] pp;
      logic [W-1:0] s;
      logic [W:0]   c;

      assign pp   = A & {W{B[i]}};
      assign c[0] = 1'b0;

      for (genvar j = 0; j < W; j++) begin : g_fa
         full_adder u_fa (
            .a    (pp[j]),
            .b    (up0[i][j]),
            .cin  (c[j]),
            .s    (s[j]),
            .cout (c[j+1])
         );
      end

      assign lo0[i]   = s[0];
      assign up0[i+1] = {c[W], s[W-1:1]};
   end

   assign P = {up0[W], lo0};

   logic           res_valid;
   logic [2*W-1:0] res_prod;

`ifdef MULTIPLIER_PIPE_EN
   logic [W-1:0] s1_up;
   logic [1:0]   s1_lo;
   logic [W-1:0] s1_a;
   logic [W-1:0] s1_b;
   logic         s1_valid;

   // NOTE: async reset clears the stage too, so an in-flight result never survives a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_up    <= '0;
         s1_lo    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_up <= up0[2];
            s1_lo <= lo0[1:0];
            s1_a  <= A;
            s1_b  <= B;
         end
      end
   end

   // Remaining rows rebuilt from the staged operands so P itself stays unregistered.
   logic [W-1:0] up1 [2:W];
   logic [W-1:0] lo1;

   assign up1[2]   = s1_up;
   assign lo1[1:0] = s1_lo;

   for (genvar i = 2; i < W; i++) begin : g_tail
      logic [W-1:0] pp;
      logic [W-1:0] s;
      logic [W:0]   c;

      assign pp   = s1_a & {W{s1_b[i]}};
      assign c[0] = 1'b0;

      for (genvar j = 0; j < W; j++) begin : g_fa
         full_adder u_fa (
            .a    (pp[j]),
            .b    (up1[i][j]),
            .cin  (c[j]),
            .s    (s[j]),
            .cout (c[j+1])
         );
      end

      assign lo1[i]   = s[0];
      assign up1[i+1] = {c[W], s[W-1:1]};
   end

   assign res_valid = s1_valid;
   assign res_prod  = {up1[W], lo1};
`else
   assign res_valid = in_valid;
   assign res_prod  = P;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         P_q       <= '0;
         out_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
         out_valid <= res_valid;
         if (res_valid) begin
            P_q <= res_prod;
         end
      end
   end

endmodule

// File: tb/tb_multiplier_2x2.sv
// Self-checking bench for multiplier_2x2: directed tables, hand sequences and random
// stimulus against a latency-aware arithmetic model; W=2 main instance plus a W=8 instance.
module tb_multiplier_2x2;

`ifdef MULTIPLIER_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic [1:0]  A, B;
   logic        in_valid;
   logic [3:0]  P, P_q;
   logic        out_valid;

   logic [7:0]  A8, B8;
   logic        in_valid8;
   logic [15:0] P8, P_q8;
   logic        out_valid8;

   multiplier_2x2 #(.W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .in_valid  (in_valid),
      .P         (P),
      .P_q       (P_q),
      .out_valid (out_valid)
   );

   multiplier_2x2 #(.W(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A8),
      .B         (B8),
      .in_valid  (in_valid8),
      .P         (P8),
      .P_q       (P_q8),
      .out_valid (out_valid8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int a;
      int b;
      int p;
   } vec_t;

   typedef struct {
      bit v;
      int p;
   } stage_t;

   int     n_checks = 0;
   int     n_fail   = 0;
   stage_t dl [LAT];
   bit     exp_valid;
   int     exp_pq;
   vec_t   comb_tab [9];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < LAT; k++) begin
         dl[k].v = 1'b0;
         dl[k].p = 0;
      end
      exp_valid = 1'b0;
      exp_pq    = 0;
   endtask

   // Enters and leaves at a falling edge; the result of a capture appears LAT edges later.
   task automatic cycle(input string tag, input int a, input int b, input bit v);
      A        = 2'(a);
      B        = 2'(b);
      in_valid = v;
      @(posedge clk);
      for (int k = LAT - 1; k > 0; k--) dl[k] = dl[k-1];
      dl[0].v = v;
      dl[0].p = a * b;
      exp_valid = dl[LAT-1].v;
      if (exp_valid) exp_pq = dl[LAT-1].p;
      #1;
      check({tag, " P"}, P, a * b);
      check({tag, " P_q"}, P_q, exp_pq);
      check({tag, " out_valid"}, out_valid, exp_valid);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      comb_tab[0] = '{3, 3, 9};
      comb_tab[1] = '{3, 1, 3};
      comb_tab[2] = '{2, 2, 4};
      comb_tab[3] = '{1, 3, 3};
      comb_tab[4] = '{3, 2, 6};
      comb_tab[5] = '{1, 2, 2};
      comb_tab[6] = '{2, 1, 2};
      comb_tab[7] = '{1, 1, 1};
      comb_tab[8] = '{2, 3, 6};

      rst_n     = 1'b0;
      A         = '0;
      B         = '0;
      in_valid  = 1'b0;
      A8        = '0;
      B8        = '0;
      in_valid8 = 1'b0;
      model_reset();

      #3;
      check("reset P_q", P_q, 0);
      check("reset out_valid", out_valid, 0);
      check("reset P_q8", P_q8, 0);

      // Combinational product is independent of reset and in_valid.
      for (int i = 0; i < 9; i++) begin
         A = 2'(comb_tab[i].a);
         B = 2'(comb_tab[i].b);
         #10;
         check($sformatf("comb %0dx%0d", comb_tab[i].a, comb_tab[i].b), P, comb_tab[i].p);
      end
      check("reset hold P_q", P_q, 0);

      @(negedge clk);
      rst_n = 1'b1;

      // Single capture then idle: P_q holds 6, out_valid pulses once.
      cycle("hold", 3, 2, 1'b1);
      for (int i = 0; i < 3; i++) cycle("hold idle", int'($urandom_range(3)), int'($urandom_range(3)), 1'b0);
      check("hold final P_q", P_q, 6);

      // Exhaustive back-to-back sweep.
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            cycle("sweep", a, b, 1'b1);
      for (int i = 0; i < LAT; i++) cycle("sweep flush", 0, 0, 1'b0);

      // Streaming (3,3),(2,2),(1,3) -> 9,4,3 on consecutive cycles.
      cycle("stream", 3, 3, 1'b1);
      cycle("stream", 2, 2, 1'b1);
      cycle("stream", 1, 3, 1'b1);
      for (int i = 0; i < LAT; i++) cycle("stream flush", 0, 0, 1'b0);

      // Reset asserted mid-stream between edges with results in flight.
      cycle("pre-reset", 1, 3, 1'b1);
      cycle("pre-reset", 2, 3, 1'b1);
      #2;
      rst_n    = 1'b0;
      A        = 2'd3;
      B        = 2'd3;
      in_valid = 1'b1;
      #1;
      check("async reset P_q", P_q, 0);
      check("async reset out_valid", out_valid, 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("in reset P_q", P_q, 0);
         check("in reset out_valid", out_valid, 0);
      end
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      cycle("post-reset", 3, 1, 1'b1);
      cycle("post-reset", 1, 1, 1'b0);
      cycle("post-reset", 2, 3, 1'b1);
      for (int i = 0; i < LAT; i++) cycle("post-reset flush", 0, 0, 1'b0);

      // Random traffic with roughly 70% valid.
      for (int i = 0; i < 300; i++)
         cycle("random", int'($urandom_range(3)), int'($urandom_range(3)), ($urandom_range(9) < 7));

      // W=8 boundaries on both paths.
      A8 = 8'd255;
      B8 = 8'd255;
      in_valid8 = 1'b1;
      #1;
      check("w8 P 255x255", P8, 65025);
      @(negedge clk);
      in_valid8 = 1'b0;
      for (int i = 0; i < LAT; i++) @(negedge clk);
      check("w8 P_q 255x255", P_q8, 65025);

      A8 = 8'd0;
      B8 = 8'd200;
      in_valid8 = 1'b1;
      #1;
      check("w8 P 0x200", P8, 0);
      @(negedge clk);
      in_valid8 = 1'b0;
      for (int i = 0; i < LAT; i++) @(negedge clk);
      check("w8 P_q 0x200", P_q8, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
